int_exec_unit: RTL and testbench
================================

# int_exec_unit

Integer execution unit on the consumer side of the dispatcher's integer issue queue. It pops ready integer entries from the first-word-fall-through int_exec_fifo and executes R-type and I-type ALU operations and conditional branches. It broadcasts results on the common data bus (CDB) through a request/grant handshake with the CDB arbiter. It replaces the behavioural integer execution model currently used on the bench.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- TAG_W, 6, physical/ROB tag width

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- i_fifo_empty  in  1  int issue FIFO empty flag
- i_fifo_data  in  int_fifo_data (101)  FIFO head: opcode[100:94], func3[93:91], func7[90:84], rs1_data[83:52], rs1_valid[51], rs1_tag[50:45], rs2_data[44:13], rs2_valid[12], rs2_tag[11:6], rd_tag[5:0]
- o_fifo_rd  out  1  pop strobe; consumes the head entry at the end of the cycle
- i_flush  in  1  kill all in-flight work (mispredict recovery)
- i_cdb_grant  in  1  arbiter grant for this unit
- o_cdb_req  out  1  result pending
- o_cdb_valid  out  1  ALU result broadcast
- o_cdb_tag  out  TAG_W  rd_tag of the broadcast
- o_cdb_data  out  DATA_W  ALU result
- o_cdb_branch  out  1  branch-resolution broadcast
- o_cdb_branch_taken  out  1  branch outcome; meaningful only with o_cdb_branch

## Operation
- Two pipeline registers: EX (captured FIFO entry plus valid bit) and WB (valid, tag, data, is_branch, taken).
- Entries are ready by dispatcher contract. rs1_valid and rs2_valid are not inspected. For I-type, rs2_data carries the sign-extended immediate.
- R-type (7'h33): func3 0 gives ADD (func7 7'h00) or SUB (func7 7'h20); 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5 SRL (func7 7'h00) or SRA (func7 7'h20); 6 OR; 7 AND. Any other func7 gives result 0.
- Shift amount is b[4:0]. SLT and SLTU produce 32'h1 or 32'h0.
- I-type (7'h13): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, decoded on the same func3/func7 rules.
- BRANCH (7'h63): func3 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; func3 2 or 3 gives taken=0. A branch writes WB with is_branch=1, data 0, tag rd_tag.
- Opcode 7'h00 is a bubble: it is popped and dropped at EX and never enters WB.
- Any other opcode: result 0, broadcast as an ALU result.
- Control equations:
  - wb_fire = wb_valid & i_cdb_grant & !i_flush
  - ex_adv = !wb_valid | wb_fire
  - o_fifo_rd = !i_fifo_empty & !i_flush & (!ex_valid | ex_adv)
- o_cdb_req = wb_valid & !i_flush.
- o_cdb_valid = wb_fire & !is_branch. o_cdb_branch = wb_fire & is_branch. o_cdb_branch_taken = wb_fire & taken.
- o_cdb_tag and o_cdb_data are driven from WB, or 0 when not firing.
- WB holds its contents unchanged while o_cdb_req=1 and no grant arrives. EX stalls behind it.
- i_flush: EX and WB valid are cleared at the next edge, no pop occurs, and no broadcast occurs in the flush cycle even if granted.
- Grant while WB is empty is ignored.

## Timing
- Reset: all outputs 0; EX and WB valid 0. Reset is asynchronous mid-operation: in-flight entries are lost and outputs return to 0 immediately.
- Pop in cycle c leads to EX valid in c+1, WB valid and o_cdb_req in c+2. With grant in c+2, the broadcast is in c+2. Pop-to-broadcast latency is 2 cycles.
- Throughput is one op per cycle with grant held high. A continuous FIFO stream yields back-to-back CDB broadcasts.
- Grant withheld for N cycles delays the broadcast by N cycles with no loss or duplication. The FIFO is popped at most twice beyond the held result (EX plus WB occupancy).
- FIFO going empty mid-stream: bubbles appear on the CDB and no spurious valid is raised.
- Grant and flush in the same cycle: flush wins and nothing is broadcast.
- Results are exactly DATA_W bits; overflow wraps modulo 2^32.

## Structure
- Shared package (utils): int_fifo_data struct, opcode constants R_TYPE, I_TYPE, BRANCH_TYPE, func3/func7 encodings, TAG_W.
- Sub-module int_alu: purely combinational (opcode, func3, func7, a, b) → (result, is_branch, taken). It is instantiated once, between EX and WB.
- The top level holds the EX/WB registers and the handshake logic.

## Test plan
- ADD: rs1=0x14, rs2=0x1e, rd_tag=0x05, grant tied 1 → two cycles after pop, o_cdb_valid=1, tag 0x05, data 0x32.
- SUB, XORI, SRA stream: SUB 0x3c−0x14, XORI 0xff^0x0f, SRA 0x80000000>>4 → back-to-back broadcasts 0x28, 0xf0, 0xf8000000.
- BNE: rs1=0x14, rs2=0x1e, then BEQ with equal operands → o_cdb_branch=1 with taken=1 both times, and o_cdb_valid stays 0.
- Grant held low for 5 cycles with 4 entries queued → o_cdb_req stays high, exactly 2 pops occur, then 4 ordered broadcasts follow with no duplication.
- Flush while EX and WB are full and grant=1 in the same cycle → no broadcast, both stages empty next cycle, FIFO head not popped in the flush cycle.
- Opcode 0 entry between two ADDs → it is popped and no CDB activity occurs for it. Assert rst_n low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/int_exec_unit_pkg.sv
// Shared definitions for the integer execution unit.
//   - int_fifo_data: layout of one int issue FIFO entry (101 bits)
//   - ex_entry_t: subset of an entry held in the EX stage
//   - opcode, func3 and func7 encodings used by the ALU decode
package int_exec_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] rs1_data;
        logic        rs1_valid;
        logic [5:0]  rs1_tag;
        logic [31:0] rs2_data;
        logic        rs2_valid;
        logic [5:0]  rs2_tag;
        logic [5:0]  rd_tag;
    } int_fifo_data;

    // Operand readiness is guaranteed by the dispatcher, so EX keeps only what the ALU needs.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
    } ex_entry_t;

    localparam logic [6:0] OP_BUBBLE   = 7'h00;
    localparam logic [6:0] R_TYPE      = 7'h33;
    localparam logic [6:0] I_TYPE      = 7'h13;
    localparam logic [6:0] BRANCH_TYPE = 7'h63;

    // ALU func3
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // Branch func3
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/int_exec_unit_if.sv
// FIFO-consumer and CDB-producer signal bundle of the integer execution unit.
//   master: the execution unit (pops the FIFO, requests and drives the CDB)
//   slave : the environment (FIFO, flush source, CDB arbiter)
interface int_exec_unit_if
    import int_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
);
    logic              i_fifo_empty;
    int_fifo_data      i_fifo_data;
    logic              o_fifo_rd;
    logic              i_flush;
    logic              i_cdb_grant;
    logic              o_cdb_req;
    logic              o_cdb_valid;
    logic [TAG_W-1:0]  o_cdb_tag;
    logic [DATA_W-1:0] o_cdb_data;
    logic              o_cdb_branch;
    logic              o_cdb_branch_taken;

    modport master (
        input  i_fifo_empty, i_fifo_data, i_flush, i_cdb_grant,
        output o_fifo_rd, o_cdb_req, o_cdb_valid, o_cdb_tag, o_cdb_data,
               o_cdb_branch, o_cdb_branch_taken
    );

    modport slave (
        output i_fifo_empty, i_fifo_data, i_flush, i_cdb_grant,
        input  o_fifo_rd, o_cdb_req, o_cdb_valid, o_cdb_tag, o_cdb_data,
               o_cdb_branch, o_cdb_branch_taken
    );
endinterface

// File: rtl/int_alu.sv
// Combinational integer ALU / branch comparator.
//   opcode, func3, func7 : decoded instruction fields
//   a, b                 : operands (b holds the sign-extended immediate for I-type)
//   result               : ALU result (0 for branches and unknown encodings)
//   is_branch, taken     : branch resolution
module int_alu
    import int_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              is_branch,
    output logic              taken
);
    logic [4:0] shamt;
    logic       f7_base;
    logic       f7_alt;
    logic       is_r;
    logic       lt_s;
    logic       lt_u;

    assign shamt   = b[4:0];
    assign f7_base = (func7 == F7_BASE);
    assign f7_alt  = (func7 == F7_ALT);
    assign is_r    = (opcode == R_TYPE);
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;

    always_comb begin
        result    = '0;
        is_branch = 1'b0;
        taken     = 1'b0;
        case (opcode)
            R_TYPE, I_TYPE: begin
                // I-type func7 is only meaningful for shifts; ADDI never becomes a subtract.
                case (func3)
                    F3_ADD_SUB: begin
                        if (!is_r || f7_base) result = a + b;
                        else if (f7_alt)      result = a - b;
                    end
                    F3_SLL:  if (f7_base) result = a << shamt;
                    F3_SLT:  if (!is_r || f7_base) result = {{(DATA_W-1){1'b0}}, lt_s};
                    F3_SLTU: if (!is_r || f7_base) result = {{(DATA_W-1){1'b0}}, lt_u};
                    F3_XOR:  if (!is_r || f7_base) result = a ^ b;
                    F3_SRL_SRA: begin
                        if (f7_base)     result = a >> shamt;
                        else if (f7_alt) result = $unsigned($signed(a) >>> shamt);
                    end
                    F3_OR:   if (!is_r || f7_base) result = a | b;
                    F3_AND:  if (!is_r || f7_base) result = a & b;
                    default: result = '0;
                endcase
            end
            BRANCH_TYPE: begin
                is_branch = 1'b1;
                case (func3)
                    F3_BEQ:  taken = (a == b);
                    F3_BNE:  taken = (a != b);
                    F3_BLT:  taken = lt_s;
                    F3_BGE:  taken = !lt_s;
                    F3_BLTU: taken = lt_u;
                    F3_BGEU: taken = !lt_u;
                    default: taken = 1'b0;
                endcase
            end
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/int_exec_unit.sv
// Integer execution unit: pops the int issue FIFO, executes in a two-stage EX/WB pipeline and
// broadcasts on the CDB under a request/grant handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : FIFO pop side, flush, CDB request/grant and broadcast (master modport)
module int_exec_unit
    import int_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
) (
    input logic             clk,
    input logic             rst_n,
    int_exec_unit_if.master bus
);
    ex_entry_t         ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;
    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_branch_q, wb_branch_d;
    logic              wb_taken_q, wb_taken_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_is_branch;
    logic              alu_taken;

    logic wb_fire;
    logic ex_adv;
    logic fifo_rd;

    // Operand tags/valids are not needed once an entry has issued.
    logic unused_fifo_bits;
    assign unused_fifo_bits = ^{bus.i_fifo_data.rs1_valid, bus.i_fifo_data.rs1_tag,
                                bus.i_fifo_data.rs2_valid, bus.i_fifo_data.rs2_tag};

    int_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode    (ex_q.opcode),
        .func3     (ex_q.func3),
        .func7     (ex_q.func7),
        .a         (ex_q.a),
        .b         (ex_q.b),
        .result    (alu_result),
        .is_branch (alu_is_branch),
        .taken     (alu_taken)
    );

    assign wb_fire = wb_valid_q & bus.i_cdb_grant & ~bus.i_flush;
    assign ex_adv  = ~wb_valid_q | wb_fire;
    // rst_n gate keeps the pop strobe low while reset is held.
    assign fifo_rd = rst_n & ~bus.i_fifo_empty & ~bus.i_flush & (~ex_valid_q | ex_adv);

    always_comb begin
        ex_d        = ex_q;
        ex_valid_d  = ex_valid_q;
        wb_valid_d  = wb_valid_q;
        wb_tag_d    = wb_tag_q;
        wb_data_d   = wb_data_q;
        wb_branch_d = wb_branch_q;
        wb_taken_d  = wb_taken_q;
        if (bus.i_flush) begin
            ex_valid_d = 1'b0;
            wb_valid_d = 1'b0;
        end else begin
            if (ex_adv) begin
                // Bubbles are consumed here and never reach WB.
                wb_valid_d  = ex_valid_q && (ex_q.opcode != OP_BUBBLE);
                wb_tag_d    = TAG_W'(ex_q.tag);
                wb_data_d   = alu_result;
                wb_branch_d = alu_is_branch;
                wb_taken_d  = alu_taken;
            end
            if (fifo_rd) begin
                ex_valid_d = 1'b1;
                ex_d       = '{opcode: bus.i_fifo_data.opcode,
                               func3:  bus.i_fifo_data.func3,
                               func7:  bus.i_fifo_data.func7,
                               a:      bus.i_fifo_data.rs1_data,
                               b:      bus.i_fifo_data.rs2_data,
                               tag:    bus.i_fifo_data.rd_tag};
            end else if (ex_adv) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_valid_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
            wb_branch_q <= 1'b0;
            wb_taken_q  <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            ex_valid_q  <= ex_valid_d;
            wb_valid_q  <= wb_valid_d;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
            wb_branch_q <= wb_branch_d;
            wb_taken_q  <= wb_taken_d;
        end
    end

    assign bus.o_fifo_rd          = fifo_rd;
    assign bus.o_cdb_req          = wb_valid_q & ~bus.i_flush;
    assign bus.o_cdb_valid        = wb_fire & ~wb_branch_q;
    assign bus.o_cdb_branch       = wb_fire & wb_branch_q;
    assign bus.o_cdb_branch_taken = wb_fire & wb_taken_q;
    assign bus.o_cdb_tag          = wb_fire ? wb_tag_q : '0;
    assign bus.o_cdb_data         = wb_fire ? wb_data_q : '0;
endmodule

// File: tb/tb_int_exec_unit.sv
module tb_int_exec_unit;
    import int_exec_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int_exec_unit_if #(.DATA_W(32), .TAG_W(6)) bus ();

    int_exec_unit #(
        .DATA_W (32),
        .TAG_W  (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        br;
        logic        tk;
    } exp_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_br;
        logic        exp_tk;
    } vec_t;

    int_fifo_data fifo_q[$];
    exp_t         exp_q[$];
    vec_t         vecs[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int bcast_cnt = 0;
    int first_b = -1;
    int last_b = -1;
    logic samp_req;
    logic samp_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] d, input logic br, input logic tk);
        vec_t v;
        v = '{op: op, f3: f3, f7: f7, a: a, b: b, exp_data: d, exp_br: br, exp_tk: tk};
        return v;
    endfunction

    task automatic refresh_fifo();
        bus.i_fifo_empty = (fifo_q.size() == 0);
        bus.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input vec_t v, input logic [5:0] tag);
        int_fifo_data e;
        exp_t x;
        e = '0;
        e.opcode   = v.op;
        e.func3    = v.f3;
        e.func7    = v.f7;
        e.rs1_data = v.a;
        e.rs1_valid = 1'b1;
        e.rs2_data = v.b;
        e.rs2_valid = 1'b1;
        e.rd_tag   = tag;
        fifo_q.push_back(e);
        if (v.op != OP_BUBBLE) begin
            x = '{tag: tag, data: v.exp_data, br: v.exp_br, tk: v.exp_tk};
            exp_q.push_back(x);
        end
        refresh_fifo();
    endtask

    // One clock: sample/score at negedge, then apply the FIFO pop just after the rising edge.
    task automatic step();
        exp_t x;
        @(negedge clk);
        cyc++;
        samp_req = bus.o_cdb_req;
        samp_rd  = bus.o_fifo_rd;
        if (bus.o_cdb_valid && bus.o_cdb_branch)
            check("valid_and_branch", 64'd1, 64'd0);
        if (bus.o_cdb_valid || bus.o_cdb_branch) begin
            bcast_cnt++;
            last_b = cyc;
            if (first_b < 0) first_b = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_bcast", {25'd0, bus.o_cdb_tag, bus.o_cdb_data, 1'b1}, 64'd0);
            end else begin
                x = exp_q.pop_front();
                check("cdb_result",
                      {24'd0, bus.o_cdb_tag, bus.o_cdb_data, bus.o_cdb_branch,
                       bus.o_cdb_branch_taken},
                      {24'd0, x.tag, x.data, x.br, x.tk});
            end
        end else begin
            check("idle_zero", {25'd0, bus.o_cdb_tag, bus.o_cdb_data, bus.o_cdb_branch_taken},
                  64'd0);
        end
        if (samp_rd) pop_cnt++;
        @(posedge clk);
        #1;
        if (samp_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return {20'd0, bus.o_fifo_rd, bus.o_cdb_req, bus.o_cdb_valid, bus.o_cdb_tag,
                bus.o_cdb_branch, bus.o_cdb_branch_taken, 1'b0};
    endfunction

    initial begin
        int p0;
        int b0;
        vec_t add_v;

        bus.i_fifo_empty = 1'b1;
        bus.i_fifo_data  = '0;
        bus.i_flush      = 1'b0;
        bus.i_cdb_grant  = 1'b0;

        // Hand-computed vectors.
        vecs.push_back(mk(R_TYPE, 3'd0, 7'h00, 32'h14, 32'h1e, 32'h32, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd0, 7'h20, 32'h3c, 32'h14, 32'h28, 0, 0));
        vecs.push_back(mk(I_TYPE, 3'd4, 7'h00, 32'hff, 32'h0f, 32'hf0, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd5, 7'h20, 32'h80000000, 32'h4, 32'hf8000000, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd5, 7'h00, 32'h80000000, 32'h4, 32'h08000000, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd1, 7'h00, 32'h1, 32'h21, 32'h2, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd2, 7'h00, 32'hffffffff, 32'h1, 32'h1, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd3, 7'h00, 32'hffffffff, 32'h1, 32'h0, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd6, 7'h00, 32'hf0f0, 32'h0f0f, 32'hffff, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd7, 7'h00, 32'hff00ff00, 32'h0ff00ff0, 32'h0f000f00, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd0, 7'h00, 32'hffffffff, 32'h2, 32'h1, 0, 0));
        vecs.push_back(mk(I_TYPE, 3'd0, 7'h00, 32'h5, 32'hfffffffd, 32'h2, 0, 0));
        vecs.push_back(mk(I_TYPE, 3'd2, 7'h00, 32'hfffffffb, 32'hfffffffd, 32'h1, 0, 0));
        vecs.push_back(mk(I_TYPE, 3'd3, 7'h00, 32'h3, 32'hffffffff, 32'h1, 0, 0));
        vecs.push_back(mk(I_TYPE, 3'd5, 7'h20, 32'hf0000000, 32'h8, 32'hfff00000, 0, 0));
        vecs.push_back(mk(BRANCH_TYPE, 3'd1, 7'h00, 32'h14, 32'h1e, 32'h0, 1, 1));
        vecs.push_back(mk(BRANCH_TYPE, 3'd0, 7'h00, 32'h7, 32'h7, 32'h0, 1, 1));
        vecs.push_back(mk(BRANCH_TYPE, 3'd4, 7'h00, 32'hffffffff, 32'h1, 32'h0, 1, 1));
        vecs.push_back(mk(BRANCH_TYPE, 3'd5, 7'h00, 32'hffffffff, 32'h1, 32'h0, 1, 0));
        vecs.push_back(mk(BRANCH_TYPE, 3'd6, 7'h00, 32'hffffffff, 32'h1, 32'h0, 1, 0));
        vecs.push_back(mk(BRANCH_TYPE, 3'd7, 7'h00, 32'hffffffff, 32'h1, 32'h0, 1, 1));
        vecs.push_back(mk(BRANCH_TYPE, 3'd2, 7'h00, 32'h5, 32'h5, 32'h0, 1, 0));
        vecs.push_back(mk(7'h37, 3'd0, 7'h00, 32'h12, 32'h34, 32'h0, 0, 0));
        vecs.push_back(mk(R_TYPE, 3'd0, 7'h01, 32'h12, 32'h34, 32'h0, 0, 0));
        add_v = vecs[0];

        // Reset state.
        #3;
        check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_req", 64'(samp_req), 64'd0);

        // Pop-to-broadcast latency of 2 cycles.
        bus.i_cdb_grant = 1'b1;
        push(add_v, 6'h05);
        b0 = bcast_cnt;
        step();
        step();
        check("latency_early", 64'(bcast_cnt - b0), 64'd0);
        step();
        check("latency_c2", 64'(bcast_cnt - b0), 64'd1);

        // Table stream, back-to-back with grant held high.
        for (int i = 0; i < vecs.size(); i++) push(vecs[i], 6'(i + 8));
        first_b = -1;
        drain(200);
        check("back_to_back", 64'(last_b - first_b), 64'(vecs.size() - 1));
        step();

        // Grant withheld for 5 cycles with 4 entries queued.
        bus.i_cdb_grant = 1'b0;
        p0 = pop_cnt;
        b0 = bcast_cnt;
        for (int i = 0; i < 4; i++) push(vecs[i], 6'(i + 40));
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 2) check("req_held", 64'(samp_req), 64'd1);
        end
        check("stall_pops", 64'(pop_cnt - p0), 64'd2);
        check("stall_no_bcast", 64'(bcast_cnt - b0), 64'd0);
        bus.i_cdb_grant = 1'b1;
        drain(50);
        check("stall_bcasts", 64'(bcast_cnt - b0), 64'd4);
        step();

        // Flush with EX and WB full and grant in the same cycle.
        bus.i_cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) push(vecs[i], 6'(i + 50));
        step();
        step();
        check("flush_setup_req", 64'(bus.o_cdb_req), 64'd1);
        bus.i_cdb_grant = 1'b1;
        bus.i_flush = 1'b1;
        p0 = pop_cnt;
        b0 = bcast_cnt;
        step();
        bus.i_flush = 1'b0;
        check("flush_no_bcast", 64'(bcast_cnt - b0), 64'd0);
        check("flush_no_pop", 64'(pop_cnt - p0), 64'd0);
        check("flush_head_kept", 64'(fifo_q.size()), 64'd1);
        check("flush_req_low", 64'(samp_req), 64'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        step();
        check("flush_wb_empty", 64'(samp_req), 64'd0);
        drain(20);
        step();

        // Bubble between two ADDs.
        p0 = pop_cnt;
        b0 = bcast_cnt;
        first_b = -1;
        push(add_v, 6'h21);
        push(mk(OP_BUBBLE, 3'd0, 7'h00, 32'h1, 32'h1, 32'h0, 0, 0), 6'h22);
        push(add_v, 6'h23);
        drain(20);
        check("bubble_pops", 64'(pop_cnt - p0), 64'd3);
        check("bubble_bcasts", 64'(bcast_cnt - b0), 64'd2);
        check("bubble_gap", 64'(last_b - first_b), 64'd2);
        step();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) push(add_v, 6'(i + 60));
        step();
        step();
        check("pre_reset_req", 64'(bus.o_cdb_req), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        check("async_reset_data", {32'd0, bus.o_cdb_data}, 64'd0);
        fifo_q.delete();
        exp_q.delete();
        refresh_fifo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = bcast_cnt;
        push(vecs[1], 6'h11);
        drain(20);
        check("recover_bcast", 64'(bcast_cnt - b0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
